stk_pipe_mem_sram_pipe: RTL and testbench

STK_PIPE_MEM_SRAM_PIPE -- requirements
Module: stk_pipe_mem_sram_pipe

---
 rtl/stk_pipe_mem_pkg.sv | 18 +
 rtl/generic_sram_1rw.sv | 29 ++
 rtl/stk_pipe_mem_sram_pipe.sv | 172 +++++++++++++++++
 tb/tb_stk_pipe_mem_sram_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pipe_mem_pkg.sv
// Shared definitions for the pipelined SRAM wrapper: controller states and
// the legal range of read latencies.
package stk_pipe_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // True when a requested read latency is one the pipeline can build.
    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/generic_sram_1rw.sv
// Generic single-port synchronous SRAM: one read or write per cycle, read
// data registered and held until the next read. Contents are never reset.
module generic_sram_1rw #(
    parameter int W = 12,
    parameter int N = 1024,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem_r [N];

    // Storage array and registered read port; q only moves on a read.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem_r[addr] <= din;
            end else begin
                q <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/stk_pipe_mem_sram_pipe.sv
// Pipelined single-port memory with optional clear-after-reset sequence,
// out-of-range detection and a 1- or 2-cycle read pipeline.
module stk_pipe_mem_sram_pipe
    import stk_pipe_mem_pkg::*;
#(
    parameter int           W        = 12,
    parameter int           N        = 1024,
    parameter int           RD_LAT   = 1,
    parameter bit           INIT_EN  = 1'b1,
    parameter logic [W-1:0] INIT_VAL = '0,
    localparam int          AW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_ce,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [W-1:0]  i_din,
    output logic          o_ready,
    output logic [W-1:0]  o_dout,
    output logic          o_dout_vld,
    output logic          o_err
);

    // Depth widened by one bit so N = 2**AW still compares correctly.
    localparam logic [AW:0]   N_EXT     = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam mem_state_e    RST_STATE = INIT_EN ? ST_INIT : ST_READY;

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("stk_pipe_mem_sram_pipe: RD_LAT must be 1 or 2");
    end
    if (N < 2) begin : g_bad_depth
        $error("stk_pipe_mem_sram_pipe: N must be at least 2");
    end

    mem_state_e    state_r;
    mem_state_e    state_nxt_s;
    logic [AW-1:0] init_cnt_r;
    logic [AW-1:0] init_cnt_nxt_s;

    logic          accept_s;
    logic          in_range_s;
    logic          rd_acc_s;
    logic          mem_ce_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [W-1:0]  mem_din_s;
    logic [W-1:0]  mem_q_s;

    logic          rd1_vld_r;
    logic          err1_r;
    logic          zero_r;
    logic [W-1:0]  rd_data_s;

    assign o_ready = (state_r == ST_READY);

    // Controller state and clear-sequence address counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= RST_STATE;
            init_cnt_r <= {AW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // Next state: walk every address once in INIT, then stay in READY.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_ADDR) begin
                    state_nxt_s    = ST_READY;
                    init_cnt_nxt_s = {AW{1'b0}};
                end else begin
                    init_cnt_nxt_s = init_cnt_r + AW'(1);
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
            end
            default: begin
                state_nxt_s    = RST_STATE;
                init_cnt_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // Port mux: the clear counter owns the array in INIT, the requester in
    // READY; out-of-range requests never reach the array.
    always_comb begin
        accept_s   = o_ready & i_ce;
        in_range_s = ({1'b0, i_addr} < N_EXT);
        rd_acc_s   = accept_s & ~i_we;
        if (state_r == ST_INIT) begin
            mem_ce_s   = 1'b1;
            mem_we_s   = 1'b1;
            mem_addr_s = init_cnt_r;
            mem_din_s  = INIT_VAL;
        end else begin
            mem_ce_s   = accept_s & in_range_s;
            mem_we_s   = i_we;
            mem_addr_s = i_addr;
            mem_din_s  = i_din;
        end
    end

    generic_sram_1rw #(
        .W (W),
        .N (N)
    ) u_sram (
        .clk  (clk),
        .ce   (mem_ce_s),
        .we   (mem_we_s),
        .addr (mem_addr_s),
        .din  (mem_din_s),
        .q    (mem_q_s)
    );

    // First pipeline stage: read valid, error flag, and whether the last
    // completed read was out of range (its data must read as zero).
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd1_vld_r <= 1'b0;
            err1_r    <= 1'b0;
            zero_r    <= 1'b1;
        end else begin
            rd1_vld_r <= rd_acc_s;
            err1_r    <= accept_s & ~in_range_s;
            if (rd_acc_s) begin
                zero_r <= ~in_range_s;
            end
        end
    end

    // The SRAM output register only changes on in-range reads, so together
    // with zero_r it already holds the last valid value.
    assign rd_data_s = zero_r ? {W{1'b0}} : mem_q_s;

    if (RD_LAT == 2) begin : g_lat2
        logic [W-1:0] dout2_r;
        logic         vld2_r;
        logic         err2_r;

        // Plain output register stage for the two-cycle latency.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                dout2_r <= {W{1'b0}};
                vld2_r  <= 1'b0;
                err2_r  <= 1'b0;
            end else begin
                vld2_r <= rd1_vld_r;
                err2_r <= err1_r;
                if (rd1_vld_r) begin
                    dout2_r <= rd_data_s;
                end
            end
        end

        assign o_dout     = dout2_r;
        assign o_dout_vld = vld2_r;
        assign o_err      = err2_r;
    end else begin : g_lat1
        assign o_dout     = rd_data_s;
        assign o_dout_vld = rd1_vld_r;
        assign o_err      = err1_r;
    end

endmodule

// File: tb/tb_stk_pipe_mem_sram_pipe.sv
// Bench for stk_pipe_mem_sram_pipe: two instances (defaults; N=1000 with
// RD_LAT=2 and no clear sequence) checked against a queue-based model.
module tb_stk_pipe_mem_sram_pipe;

    typedef struct { bit ce; bit we; int addr; int din; } req_t;
    typedef struct { bit vld; bit err; int data; } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_ce = 1'b0, a_we = 1'b0;
    logic [9:0]  a_addr = 10'd0;
    logic [11:0] a_din = 12'd0;
    logic        a_ready, a_vld, a_err;
    logic [11:0] a_dout;
    logic        b_ce = 1'b0, b_we = 1'b0;
    logic [9:0]  b_addr = 10'd0;
    logic [11:0] b_din = 12'd0;
    logic        b_ready, b_vld, b_err;
    logic [11:0] b_dout;

    int   checks = 0;
    int   errors = 0;
    int   mem_a [1024];
    int   mem_b [1000];
    bit   wr_b  [1000];
    int   last_a = 0;
    int   last_b = 0;
    req_t req_q [$];

    always #5 clk = ~clk;

    stk_pipe_mem_sram_pipe #(.W(12), .N(1024), .RD_LAT(1), .INIT_EN(1'b1), .INIT_VAL(12'h000)) dut_a (
        .clk(clk), .arst_n(rst_n), .i_ce(a_ce), .i_we(a_we), .i_addr(a_addr), .i_din(a_din),
        .o_ready(a_ready), .o_dout(a_dout), .o_dout_vld(a_vld), .o_err(a_err));

    stk_pipe_mem_sram_pipe #(.W(12), .N(1000), .RD_LAT(2), .INIT_EN(1'b0), .INIT_VAL(12'h000)) dut_b (
        .clk(clk), .arst_n(rst_n), .i_ce(b_ce), .i_we(b_we), .i_addr(b_addr), .i_din(b_din),
        .o_ready(b_ready), .o_dout(b_dout), .o_dout_vld(b_vld), .o_err(b_err));

    task automatic add_req(input bit ce, input bit we, input int addr, input int din);
        req_t r;
        r.ce = ce; r.we = we; r.addr = addr; r.din = din;
        req_q.push_back(r);
    endtask

    // Plays req_q into one instance and checks every cycle's outputs.
    task automatic run_traffic(input bit sel_b, input string name);
        exp_t pipe [$];
        exp_t e;
        req_t r;
        int   lat, n, want_dout;
        logic obs_vld, obs_err;
        logic [11:0] obs_dout;
        lat = sel_b ? 2 : 1;
        n   = sel_b ? 1000 : 1024;
        for (int i = 0; i < lat; i++) begin
            e.vld = 1'b0; e.err = 1'b0; e.data = 0;
            pipe.push_back(e);
        end
        while (pipe.size() > 0) begin
            @(negedge clk);
            e = pipe.pop_front();
            if (e.vld) begin
                if (sel_b) last_b = e.data; else last_a = e.data;
            end
            want_dout = sel_b ? last_b : last_a;
            obs_vld  = sel_b ? b_vld : a_vld;
            obs_err  = sel_b ? b_err : a_err;
            obs_dout = sel_b ? b_dout : a_dout;
            checks++;
            if (obs_vld !== e.vld) begin
                errors++;
                $display("FAIL %s dout_vld: got %b expected %b at %0t", name, obs_vld, e.vld, $time);
            end
            checks++;
            if (obs_err !== e.err) begin
                errors++;
                $display("FAIL %s err: got %b expected %b at %0t", name, obs_err, e.err, $time);
            end
            checks++;
            if (obs_dout !== 12'(want_dout)) begin
                errors++;
                $display("FAIL %s dout: got %h expected %h at %0t", name, obs_dout, 12'(want_dout), $time);
            end
            a_ce = 1'b0;
            b_ce = 1'b0;
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                if (sel_b) begin
                    b_ce = r.ce; b_we = r.we; b_addr = 10'(r.addr); b_din = 12'(r.din);
                end else begin
                    a_ce = r.ce; a_we = r.we; a_addr = 10'(r.addr); a_din = 12'(r.din);
                end
                e.vld = 1'b0; e.err = 1'b0; e.data = 0;
                if (r.ce) begin
                    e.err = (r.addr >= n);
                    if (r.we) begin
                        if (r.addr < n) begin
                            if (sel_b) mem_b[r.addr] = r.din; else mem_a[r.addr] = r.din;
                        end
                    end else begin
                        e.vld = 1'b1;
                        if (r.addr < n) e.data = sel_b ? mem_b[r.addr] : mem_a[r.addr];
                    end
                end
                pipe.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        last_a = 0; last_b = 0;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset a_ready: got %b expected 0", a_ready); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset a_vld: got %b expected 0", a_vld); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset a_err: got %b expected 0", a_err); end
        checks++; if (a_dout !== 12'h000) begin errors++; $display("FAIL reset a_dout: got %h expected 000", a_dout); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset b_ready: got %b expected 1", b_ready); end
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL reset b_vld: got %b expected 0", b_vld); end
        checks++; if (b_dout !== 12'h000) begin errors++; $display("FAIL reset b_dout: got %h expected 000", b_dout); end
    endtask

    task automatic test_init_a();
        int cnt;
        bit seen;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; seen = 1'b0;
        while (a_ready !== 1'b1 && cnt < 3000) begin
            if (a_vld !== 1'b0) seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 1024) begin errors++; $display("FAIL init_len: got %0d cycles expected 1024", cnt); end
        checks++; if (seen) begin errors++; $display("FAIL init_vld: got dout_vld during init expected none"); end
        for (int i = 0; i < 1024; i++) mem_a[i] = 0;
        add_req(1'b1, 1'b0, 0, 0);
        add_req(1'b0, 1'b0, 0, 0);
        add_req(1'b1, 1'b0, 511, 0);
        add_req(1'b1, 1'b0, 1023, 0);
        run_traffic(1'b0, "init_reads");
    endtask

    task automatic test_random_a();
        int addr;
        for (int i = 0; i < 400; i++) begin
            addr = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
            add_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, addr, $urandom_range(0, 4095));
        end
        run_traffic(1'b0, "rand_a");
    endtask

    task automatic test_lat2_b();
        add_req(1'b1, 1'b1, 5, 12'hABC);
        add_req(1'b1, 1'b0, 5, 0);
        for (int i = 0; i < 64; i++) begin
            add_req(1'b1, 1'b1, i, i);
            wr_b[i] = 1'b1;
        end
        for (int i = 0; i < 64; i++) add_req(1'b1, 1'b0, i, 0);
        run_traffic(1'b1, "b_lat2_seq");
    endtask

    task automatic test_oor_b();
        add_req(1'b1, 1'b1, 999, 12'h7E5);
        wr_b[999] = 1'b1;
        add_req(1'b1, 1'b0, 1000, 0);
        add_req(1'b1, 1'b1, 1001, 12'h321);
        add_req(1'b0, 1'b0, 0, 0);
        add_req(1'b1, 1'b0, 999, 0);
        add_req(1'b1, 1'b0, 1023, 0);
        run_traffic(1'b1, "b_oor");
    endtask

    task automatic test_random_b();
        int  addr;
        bit  we;
        for (int i = 0; i < 400; i++) begin
            addr = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
            we   = ($urandom_range(0, 1) == 1);
            if (!we && addr < 1000 && !wr_b[addr]) we = 1'b1;
            if (we && addr < 1000) wr_b[addr] = 1'b1;
            add_req($urandom_range(0, 4) != 0, we, addr, $urandom_range(0, 4095));
        end
        run_traffic(1'b1, "rand_b");
    endtask

    task automatic test_init_restart_a();
        int cnt;
        bit seen;
        add_req(1'b1, 1'b1, 7, 12'h123);
        add_req(1'b1, 1'b1, 300, 12'h456);
        add_req(1'b1, 1'b0, 7, 0);
        run_traffic(1'b0, "pre_restart");
        @(negedge clk);
        rst_n = 1'b0;
        a_ce = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_din = 12'h555;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) @(negedge clk);
        rst_n = 1'b0;
        last_a = 0; last_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0; seen = 1'b0;
        while (a_ready !== 1'b1 && cnt < 3000) begin
            if (a_vld !== 1'b0) seen = 1'b1;
            cnt++;
            @(negedge clk);
        end
        a_ce = 1'b0;
        checks++; if (cnt != 1024) begin errors++; $display("FAIL restart_len: got %0d cycles expected 1024", cnt); end
        checks++; if (seen) begin errors++; $display("FAIL restart_vld: got dout_vld during init expected none"); end
        for (int i = 0; i < 1024; i++) mem_a[i] = 0;
        add_req(1'b1, 1'b0, 7, 0);
        add_req(1'b1, 1'b0, 300, 0);
        add_req(1'b1, 1'b0, 1023, 0);
        add_req(1'b1, 1'b0, 0, 0);
        run_traffic(1'b0, "post_restart");
    endtask

    task automatic test_reset_inflight_b();
        @(negedge clk);
        b_ce = 1'b1; b_we = 1'b0; b_addr = 10'd5;
        @(negedge clk);
        b_ce = 1'b0;
        rst_n = 1'b0;
        last_a = 0; last_b = 0;
        #1;
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL inflight_rst vld: got %b expected 0", b_vld); end
        checks++; if (b_dout !== 12'h000) begin errors++; $display("FAIL inflight_rst dout: got %h expected 000", b_dout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL inflight_after vld: got %b expected 0", b_vld); end
        add_req(1'b1, 1'b0, 5, 0);
        run_traffic(1'b1, "b_after_reset");
    endtask

    initial begin
        for (int i = 0; i < 1000; i++) begin
            wr_b[i] = 1'b0;
            mem_b[i] = 0;
        end
        test_reset();
        test_init_a();
        test_random_a();
        test_lat2_b();
        test_oor_b();
        test_random_b();
        test_init_restart_a();
        test_reset_inflight_b();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
